tgt_qstruct_sender: RTL

- Sits directly downstream of the target queue-structure stage and consumes its st_qstruct stream: per-packet queue context and descriptor, then one payload-buffer slot address per beat.
- For every beat, issues one DMA write command that moves one payload slot into the remote receive ring.
- After the packet, issues one tail-pointer notify.
- Owns the per-queue ring write pointers.

---
 rtl/tgt_qstruct_sender.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tgt_qstruct_sender.sv
// tgt_qstruct_sender: st_qstruct beats to per-slot DMA writes plus tail notify; define TGT_SENDER_STAT_EN for stat counters
module tgt_qstruct_sender #(
    parameter int QNUM_LOG   = 4,
    parameter int CTX_W      = 64,
    parameter int DESC_W     = 32,
    parameter int BUF_ADDR_W = 32,
    parameter int SLOT_LOG   = 7,
    parameter int WPTR_W     = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st_qstruct_valid,
    input  logic                  st_qstruct_last,
    input  logic [CTX_W-1:0]      st_qstruct_head_ctx,
    input  logic [DESC_W-1:0]     st_qstruct_head_desc,
    input  logic [BUF_ADDR_W-1:0] st_qstruct_buf_addr,
    output logic                  st_qstruct_ready,
    output logic                  dma_cmd_valid,
    output logic [31:0]           dma_cmd_dst,
    output logic [BUF_ADDR_W-1:0] dma_cmd_buf,
    output logic [SLOT_LOG:0]     dma_cmd_len,
    input  logic                  dma_cmd_ready,
    output logic                  ntfy_valid,
    output logic [QNUM_LOG-1:0]   ntfy_qnum,
    output logic [WPTR_W-1:0]     ntfy_wptr,
    input  logic                  ntfy_ready,
    input  logic                  wptr_clr_valid,
    input  logic [QNUM_LOG-1:0]   wptr_clr_qnum,
    output logic                  err_pulse
`ifdef TGT_SENDER_STAT_EN
    ,
    output logic [31:0]           stat_pkt_cnt,
    output logic [47:0]           stat_byte_cnt,
    output logic [15:0]           stat_err_cnt
`endif
);
    localparam int QN = 1 << QNUM_LOG;
    localparam int LEN_W = SLOT_LOG + 1;
    localparam logic [12:0] SLOT = 13'(1 << SLOT_LOG);
    typedef enum logic [1:0] {IDLE, BODY, NTFY} state_e;
    state_e                  state_q, state_d;
    logic [31:0]             base_q, base_d;
    logic [4:0]              rlog_q, rlog_d;
    logic [QNUM_LOG-1:0]     qnum_q, qnum_d;
    logic [12:0]             remain_q, remain_d;
    logic [WPTR_W-1:0]       ptr_q, ptr_d;
    logic [WPTR_W-1:0]       wptr_q [QN];
    logic                    cmd_valid_q, cmd_valid_d;
    logic [31:0]             cmd_dst_q, cmd_dst_d;
    logic [BUF_ADDR_W-1:0]   cmd_buf_q, cmd_buf_d;
    logic [LEN_W-1:0]        cmd_len_q, cmd_len_d;
    logic                    err_q, err_d;
    logic                    acc, first, has, nhs;
    logic [4:0]              ctx_rlog, cur_rlog;
    logic [QNUM_LOG-1:0]     ctx_qnum;
    logic [31:0]             cur_base;
    logic [12:0]             cur_remain, rem_next;
    logic [WPTR_W-1:0]       cur_ptr, mask, nptr;
    logic [LEN_W-1:0]        len;
    logic                    unused_bits;
    assign unused_bits = ^{st_qstruct_head_ctx[31:29], st_qstruct_head_ctx[23:QNUM_LOG], st_qstruct_head_desc[DESC_W-1:13]};
    assign ctx_qnum = st_qstruct_head_ctx[QNUM_LOG-1:0];
    // ring sizes below one slot are not meaningful, so the mask never drops under a slot
    assign ctx_rlog = (st_qstruct_head_ctx[28:24] < 5'(SLOT_LOG)) ? 5'(SLOT_LOG) : st_qstruct_head_ctx[28:24];
    assign st_qstruct_ready = (state_q != NTFY) & (~cmd_valid_q | dma_cmd_ready);
    assign acc   = st_qstruct_valid & st_qstruct_ready;
    assign first = state_q == IDLE;
    assign nhs   = (state_q == NTFY) & ntfy_ready;
    always_comb begin
        cur_base   = first ? st_qstruct_head_ctx[63:32] : base_q;
        cur_rlog   = first ? ctx_rlog : rlog_q;
        cur_remain = first ? st_qstruct_head_desc[12:0] : remain_q;
        cur_ptr    = first ? wptr_q[ctx_qnum] : ptr_q;
        has        = cur_remain != 13'd0;
        len        = (cur_remain >= SLOT) ? LEN_W'(SLOT) : cur_remain[LEN_W-1:0];
        rem_next   = cur_remain - 13'(len);
        mask       = ~({WPTR_W{1'b1}} << cur_rlog);
        nptr       = (cur_ptr + WPTR_W'(SLOT)) & mask;
    end
    always_comb begin
        state_d     = acc ? (st_qstruct_last ? NTFY : BODY) : (nhs ? IDLE : state_q);
        base_d      = (acc & first) ? st_qstruct_head_ctx[63:32] : base_q;
        rlog_d      = (acc & first) ? ctx_rlog : rlog_q;
        qnum_d      = (acc & first) ? ctx_qnum : qnum_q;
        remain_d    = acc ? rem_next : remain_q;
        ptr_d       = acc ? (has ? nptr : cur_ptr) : ptr_q;
        cmd_valid_d = (acc & has) | (cmd_valid_q & ~dma_cmd_ready);
        cmd_dst_d   = (acc & has) ? cur_base + 32'(cur_ptr) : cmd_dst_q;
        cmd_buf_d   = (acc & has) ? st_qstruct_buf_addr : cmd_buf_q;
        cmd_len_d   = (acc & has) ? len : cmd_len_q;
        err_d       = acc & (~has | (st_qstruct_last & (rem_next != 13'd0)));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            rlog_q      <= '0;
            qnum_q      <= '0;
            remain_q    <= '0;
            ptr_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_dst_q   <= '0;
            cmd_buf_q   <= '0;
            cmd_len_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            rlog_q      <= rlog_d;
            qnum_q      <= qnum_d;
            remain_q    <= remain_d;
            ptr_q       <= ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_dst_q   <= cmd_dst_d;
            cmd_buf_q   <= cmd_buf_d;
            cmd_len_q   <= cmd_len_d;
            err_q       <= err_d;
        end
    end
    // a clear on the same queue as a commit overrides it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QN; i++) wptr_q[i] <= '0;
        end else begin
            for (int i = 0; i < QN; i++)
                if (wptr_clr_valid && wptr_clr_qnum == QNUM_LOG'(i)) wptr_q[i] <= '0;
                else if (nhs && qnum_q == QNUM_LOG'(i)) wptr_q[i] <= ptr_q;
        end
    end
    assign dma_cmd_valid = cmd_valid_q;
    assign dma_cmd_dst   = cmd_dst_q;
    assign dma_cmd_buf   = cmd_buf_q;
    assign dma_cmd_len   = cmd_len_q;
    assign ntfy_valid    = state_q == NTFY;
    assign ntfy_qnum     = qnum_q;
    assign ntfy_wptr     = ptr_q;
    assign err_pulse     = err_q;
`ifdef TGT_SENDER_STAT_EN
    logic [31:0] pkt_cnt_q;
    logic [47:0] byte_cnt_q;
    logic [15:0] err_cnt_q;
    logic [48:0] byte_sum;
    assign byte_sum = {1'b0, byte_cnt_q} + 49'(cmd_len_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            byte_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (nhs && !(&pkt_cnt_q)) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (cmd_valid_q && dma_cmd_ready) byte_cnt_q <= byte_sum[48] ? '1 : byte_sum[47:0];
            if (err_q && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end
    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_byte_cnt = byte_cnt_q;
    assign stat_err_cnt  = err_cnt_q;
`endif
endmodule
